dcache_mshr: RTL and testbench
==============================

Name: dcache_mshr

Overview:
- Miss-status holding register file for the data cache. It sits between the load/store unit miss path, the memory bus, and the dcache refill port; it drives the mshr2Dcache_wr / mshr2Dcache_mem_block interface.
- It accepts dcache misses, issues BUS_LOAD requests to memory, and matches returning memory data tags to entries.
- It replays one refill per cycle into the dcache, together with the original store data and size, so the dcache merges a missed store into the refilled block.

Parameters:
- NUM_ENTRIES, 4, number of outstanding misses (power of two, ≥2).
- IDX_W, $clog2(NUM_ENTRIES), entry index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- miss_valid  in  1  dcache miss presented this cycle
- miss_addr  in  32 (ADDR)  miss byte address
- miss_is_store  in  1  miss is a store
- miss_st_size  in  2 (MEM_SIZE)  store size
- miss_data  in  32 (DATA)  store data
- mshr_stall  out  1  miss not accepted; requester retries
- mem_grant  in  1  memory port is granted to the MSHR this cycle
- proc2mem_command  out  2 (BUS_COMMAND)  BUS_LOAD or BUS_NONE
- proc2mem_addr  out  32 (ADDR)  block-aligned request address
- mem2proc_transaction_tag  in  4 (MEM_TAG)  nonzero means the request was accepted
- mem2proc_data_tag  in  4 (MEM_TAG)  tag of returning data; 0 means none
- mem2proc_data  in  64 (MEM_BLOCK)  returning block
- dcache_refill_ready  in  1  dcache write port is free this cycle
- mshr2Dcache_wr  out  1  refill write strobe
- mshr2Dcache_addr  out  32 (ADDR)  original miss address
- mshr2Dcache_mem_block  out  64 (MEM_BLOCK)  refill block
- mshr2Dcache_is_store  out  1  replayed store flag
- mshr2Dcache_st_size  out  2 (MEM_SIZE)  replayed store size
- mshr2Dcache_data  out  32 (DATA)  replayed store data
- mshr_full  out  1  no INVALID entry

Behaviour:
- Entry state machine: INVALID -> WAIT_ISSUE -> WAIT_DATA -> REFILL -> INVALID.
- Each entry holds: addr, is_store, st_size, data, mem_tag, block.
- Allocation:
  - Condition: miss_valid, an INVALID entry exists, and no valid entry has the same block address (addr[31:3]).
  - The lowest-index INVALID entry enters WAIT_ISSUE at the next edge.
- mshr_stall is combinational: miss_valid && (mshr_full || same-block match).
- Issue:
  - The lowest-index WAIT_ISSUE entry drives proc2mem_command=BUS_LOAD and proc2mem_addr={addr[31:3],3'b0}.
  - It drives these only when mem_grant=1; otherwise proc2mem_command=BUS_NONE and proc2mem_addr=0.
  - Nonzero mem2proc_transaction_tag in the same cycle: the tag is stored and the entry moves to WAIT_DATA.
  - Zero tag: the entry stays in WAIT_ISSUE and retries next cycle.
- Data return:
  - Nonzero mem2proc_data_tag equal to the mem_tag of a WAIT_DATA entry: mem2proc_data is latched into that entry and it moves to REFILL.
  - Tag 0, or a tag with no match, is ignored.
  - At most one entry matches.
- Refill: each cycle, if dcache_refill_ready, the lowest-index REFILL entry drives:
  - mshr2Dcache_wr=1
  - addr, block, is_store, st_size, data on the mshr2Dcache_* outputs
  - It returns to INVALID at the next edge.
  - All refill outputs are 0 when no refill is driven.
- Latency, miss to refill with immediate grant and tag acceptance:
  - miss at cycle t; BUS_LOAD at t+1.
  - data tag at cycle d; mshr2Dcache_wr at d+1.
- Simultaneous events:
  - Allocation, issue, data capture and refill may all occur in one cycle on different entries.
  - mshr_full is computed from current state; an entry freed this cycle is not allocatable until the next cycle.
  - A miss matching the block of an entry that is refilling this cycle still stalls.
- Reset:
  - All entries INVALID.
  - Outputs: mshr2Dcache_wr=0, mshr2Dcache_* = 0, proc2mem_command=BUS_NONE, proc2mem_addr=0, mshr_full=0, mshr_stall=0.
  - Data tags returning after a mid-operation reset find no WAIT_DATA entry and are dropped.

Optional Feature:
- MSHR_BYPASS_EN defined: a data return whose tag matches a WAIT_DATA entry is forwarded to the dcache in the same cycle when both hold:
  - dcache_refill_ready=1
  - no REFILL entry exists
- The forward uses mem2proc_data as mshr2Dcache_mem_block, and the entry goes straight to INVALID. Refill latency is then d+0.
- Otherwise the entry takes the normal REFILL path.
- MSHR_BYPASS_EN undefined: refill is always through the REFILL state (latency d+1).

Test Plan:
- Load miss 0x0000_1004, mem_grant=1, transaction_tag=3; data_tag=3 with data 0x1122334455667788 five cycles later -> BUS_LOAD addr 0x0000_1000 at t+1; mshr2Dcache_wr=1 with that block and addr 0x0000_1004 one cycle after the data (same cycle with MSHR_BYPASS_EN).
- Store miss 0x0000_2006, HALF, data 0xBEEF -> refill cycle shows is_store=1, st_size=HALF, data 0xBEEF, addr 0x0000_2006.
- Issue 4 misses to distinct blocks, then a 5th -> mshr_full=1 and mshr_stall=1 on the 5th. A second miss to 0x0000_1000 while 0x0000_1004 is pending -> mshr_stall=1.
- transaction_tag=0 for 3 cycles, then 7 -> BUS_LOAD held with identical addr for 4 cycles; entry waits for tag 7.
- Two entries with tags 2 and 5; data_tag 5 and then 2 in consecutive cycles with dcache_refill_ready=0 for 3 cycles -> no wr while ready=0; then refills one per cycle, lower index first.
- Reset asserted while an entry is in WAIT_DATA with tag 4; data_tag=4 after reset -> mshr2Dcache_wr stays 0 and all outputs stay 0.

Source files
------------

// File: rtl/dcache_mshr.sv
// Miss-status holding registers between the dcache miss path, the memory bus and the refill port.
// Define MSHR_BYPASS_EN to forward returning data straight to the dcache when the refill port is idle.
module dcache_mshr #(
  parameter int unsigned NUM_ENTRIES = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic        clock,
  input  logic        reset,
  // miss request
  input  logic        miss_valid,
  input  logic [31:0] miss_addr,
  input  logic        miss_is_store,
  input  logic [1:0]  miss_st_size,
  input  logic [31:0] miss_data,
  output logic        mshr_stall,
  // memory bus
  input  logic        mem_grant,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  input  logic [3:0]  mem2proc_transaction_tag,
  input  logic [3:0]  mem2proc_data_tag,
  input  logic [63:0] mem2proc_data,
  // dcache refill
  input  logic        dcache_refill_ready,
  output logic        mshr2Dcache_wr,
  output logic [31:0] mshr2Dcache_addr,
  output logic [63:0] mshr2Dcache_mem_block,
  output logic        mshr2Dcache_is_store,
  output logic [1:0]  mshr2Dcache_st_size,
  output logic [31:0] mshr2Dcache_data,
  output logic        mshr_full
);

  localparam logic [1:0] BusNone = 2'h0;
  localparam logic [1:0] BusLoad = 2'h1;

  typedef enum logic [1:0] {
    StInvalid,
    StWaitIssue,
    StWaitData,
    StRefill
  } ent_state_e;

  ent_state_e  state_q    [NUM_ENTRIES];
  ent_state_e  state_d    [NUM_ENTRIES];
  logic [31:0] addr_q     [NUM_ENTRIES];
  logic        is_store_q [NUM_ENTRIES];
  logic [1:0]  st_size_q  [NUM_ENTRIES];
  logic [31:0] data_q     [NUM_ENTRIES];
  logic [3:0]  tag_q      [NUM_ENTRIES];
  logic [63:0] block_q    [NUM_ENTRIES];

  logic             any_free, same_block, alloc;
  logic             issue_vld, issue_fire, tag_accept;
  logic             cap_vld, refill_vld, refill_fire, bypass;
  logic [IDX_W-1:0] free_idx, issue_idx, cap_idx, refill_idx;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    any_free   = 1'b0;
    same_block = 1'b0;
    issue_vld  = 1'b0;
    cap_vld    = 1'b0;
    refill_vld = 1'b0;
    free_idx   = '0;
    issue_idx  = '0;
    cap_idx    = '0;
    refill_idx = '0;
    for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
      if (state_q[i] == StInvalid) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end else if (addr_q[i][31:3] == miss_addr[31:3]) begin
        same_block = 1'b1;
      end
      if (state_q[i] == StWaitIssue) begin
        issue_vld = 1'b1;
        issue_idx = IDX_W'(i);
      end
      if (state_q[i] == StWaitData && mem2proc_data_tag != 4'd0 &&
          tag_q[i] == mem2proc_data_tag) begin
        cap_vld = 1'b1;
        cap_idx = IDX_W'(i);
      end
      if (state_q[i] == StRefill) begin
        refill_vld = 1'b1;
        refill_idx = IDX_W'(i);
      end
    end
  end

  assign mshr_full   = ~any_free;
  assign mshr_stall  = miss_valid & (~any_free | same_block);
  assign alloc       = miss_valid & any_free & ~same_block;
  assign issue_fire  = issue_vld & mem_grant;
  assign tag_accept  = issue_fire & (mem2proc_transaction_tag != 4'd0);
  assign refill_fire = refill_vld & dcache_refill_ready;

`ifdef MSHR_BYPASS_EN
  assign bypass = cap_vld & dcache_refill_ready & ~refill_vld;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    proc2mem_command = BusNone;
    proc2mem_addr    = '0;
    if (issue_fire) begin
      proc2mem_command = BusLoad;
      proc2mem_addr    = {addr_q[issue_idx][31:3], 3'b000};
    end
  end

  // Refill and bypass are mutually exclusive: bypass needs an empty refill queue.
  always_comb begin
    mshr2Dcache_wr        = 1'b0;
    mshr2Dcache_addr      = '0;
    mshr2Dcache_mem_block = '0;
    mshr2Dcache_is_store  = 1'b0;
    mshr2Dcache_st_size   = '0;
    mshr2Dcache_data      = '0;
    if (refill_fire) begin
      mshr2Dcache_wr        = 1'b1;
      mshr2Dcache_addr      = addr_q[refill_idx];
      mshr2Dcache_mem_block = block_q[refill_idx];
      mshr2Dcache_is_store  = is_store_q[refill_idx];
      mshr2Dcache_st_size   = st_size_q[refill_idx];
      mshr2Dcache_data      = data_q[refill_idx];
    end else if (bypass) begin
      mshr2Dcache_wr        = 1'b1;
      mshr2Dcache_addr      = addr_q[cap_idx];
      mshr2Dcache_mem_block = mem2proc_data;
      mshr2Dcache_is_store  = is_store_q[cap_idx];
      mshr2Dcache_st_size   = st_size_q[cap_idx];
      mshr2Dcache_data      = data_q[cap_idx];
    end
  end

  // Each event targets an entry in a distinct state, so updates never collide.
  always_comb begin
    for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
      state_d[i] = state_q[i];
    end
    if (refill_fire) begin
      state_d[refill_idx] = StInvalid;
    end
    if (cap_vld) begin
      state_d[cap_idx] = bypass ? StInvalid : StRefill;
    end
    if (tag_accept) begin
      state_d[issue_idx] = StWaitData;
    end
    if (alloc) begin
      state_d[free_idx] = StWaitIssue;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        state_q[i] <= StInvalid;
      end
    end else begin
      for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  // Payload needs no reset; it is only observed through a valid state.
  always_ff @(posedge clock) begin
    if (alloc) begin
      addr_q[free_idx]     <= miss_addr;
      is_store_q[free_idx] <= miss_is_store;
      st_size_q[free_idx]  <= miss_st_size;
      data_q[free_idx]     <= miss_data;
    end
    if (tag_accept) begin
      tag_q[issue_idx] <= mem2proc_transaction_tag;
    end
    if (cap_vld) begin
      block_q[cap_idx] <= mem2proc_data;
    end
  end

endmodule

// File: tb/tb_dcache_mshr.sv
// Self-checking bench for dcache_mshr: directed table, corner sequences and a randomized run
// against a behavioural model of the outstanding-miss list.
module tb_dcache_mshr;

  localparam int NE = 4;
`ifdef MSHR_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  localparam int PFree = 0;
  localparam int PIss  = 1;
  localparam int PWait = 2;
  localparam int PRef  = 3;

  typedef struct packed {
    logic        rst;
    logic        mv;
    logic [31:0] maddr;
    logic        st;
    logic [1:0]  sz;
    logic [31:0] mdata;
    logic        grant;
    logic [3:0]  ttag;
    logic [3:0]  dtag;
    logic [63:0] ddata;
    logic        ready;
  } stim_t;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] paddr;
    logic        wr;
    logic [31:0] waddr;
    logic [63:0] blk;
    logic        st;
    logic [1:0]  sz;
    logic [31:0] data;
    logic        stall;
    logic        full;
  } obs_t;

  typedef struct packed {
    stim_t in;
    obs_t  exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        miss_valid = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_is_store = 1'b0;
  logic [1:0]  miss_st_size = '0;
  logic [31:0] miss_data = '0;
  logic        mshr_stall;
  logic        mem_grant = 1'b0;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [3:0]  mem2proc_transaction_tag = '0;
  logic [3:0]  mem2proc_data_tag = '0;
  logic [63:0] mem2proc_data = '0;
  logic        dcache_refill_ready = 1'b0;
  logic        mshr2Dcache_wr;
  logic [31:0] mshr2Dcache_addr;
  logic [63:0] mshr2Dcache_mem_block;
  logic        mshr2Dcache_is_store;
  logic [1:0]  mshr2Dcache_st_size;
  logic [31:0] mshr2Dcache_data;
  logic        mshr_full;

  dcache_mshr #(.NUM_ENTRIES(NE)) dut (
    .clock                    (clock),
    .reset                    (reset),
    .miss_valid               (miss_valid),
    .miss_addr                (miss_addr),
    .miss_is_store            (miss_is_store),
    .miss_st_size             (miss_st_size),
    .miss_data                (miss_data),
    .mshr_stall               (mshr_stall),
    .mem_grant                (mem_grant),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .mem2proc_data            (mem2proc_data),
    .dcache_refill_ready      (dcache_refill_ready),
    .mshr2Dcache_wr           (mshr2Dcache_wr),
    .mshr2Dcache_addr         (mshr2Dcache_addr),
    .mshr2Dcache_mem_block    (mshr2Dcache_mem_block),
    .mshr2Dcache_is_store     (mshr2Dcache_is_store),
    .mshr2Dcache_st_size      (mshr2Dcache_st_size),
    .mshr2Dcache_data         (mshr2Dcache_data),
    .mshr_full                (mshr_full)
  );

  always #5 clock = ~clock;

  int    checks = 0;
  int    failures = 0;
  stim_t s;
  obs_t  got;

  // Reference: each outstanding miss has a phase and its payload.
  int          m_ph   [NE];
  logic [31:0] m_addr [NE];
  logic        m_st   [NE];
  logic [1:0]  m_sz   [NE];
  logic [31:0] m_data [NE];
  logic [3:0]  m_tag  [NE];
  logic [63:0] m_blk  [NE];

  task automatic chk(input string name, input obs_t g, input obs_t e);
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, g, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NE; i++) m_ph[i] = PFree;
  endtask

  task automatic model_step(output obs_t e);
    int fr, iss, cap, rf;
    bit full, hit, byp;
    fr = -1; iss = -1; cap = -1; rf = -1;
    full = 1'b1; hit = 1'b0; byp = 1'b0;
    e = '0;
    for (int i = 0; i < NE; i++) begin
      if (m_ph[i] == PFree) begin
        full = 1'b0;
        if (fr < 0) fr = i;
      end else if (m_addr[i][31:3] == s.maddr[31:3]) hit = 1'b1;
      if (m_ph[i] == PIss && iss < 0) iss = i;
      if (m_ph[i] == PWait && s.dtag != 4'd0 && m_tag[i] == s.dtag) cap = i;
      if (m_ph[i] == PRef && rf < 0) rf = i;
    end
    e.full  = full;
    e.stall = s.mv && (full || hit);
    if (iss >= 0 && s.grant) begin
      e.cmd   = 2'd1;
      e.paddr = {m_addr[iss][31:3], 3'b000};
    end
    if (rf >= 0 && s.ready) begin
      e.wr = 1'b1; e.waddr = m_addr[rf]; e.blk = m_blk[rf];
      e.st = m_st[rf]; e.sz = m_sz[rf]; e.data = m_data[rf];
    end else if (Byp && cap >= 0 && s.ready && rf < 0) begin
      byp = 1'b1;
      e.wr = 1'b1; e.waddr = m_addr[cap]; e.blk = s.ddata;
      e.st = m_st[cap]; e.sz = m_sz[cap]; e.data = m_data[cap];
    end
    if (rf >= 0 && s.ready) m_ph[rf] = PFree;
    if (cap >= 0) begin
      m_ph[cap]  = byp ? PFree : PRef;
      m_blk[cap] = s.ddata;
    end
    if (iss >= 0 && s.grant && s.ttag != 4'd0) begin
      m_ph[iss]  = PWait;
      m_tag[iss] = s.ttag;
    end
    if (s.mv && !e.stall) begin
      m_ph[fr] = PIss; m_addr[fr] = s.maddr; m_st[fr] = s.st;
      m_sz[fr] = s.sz; m_data[fr] = s.mdata;
    end
  endtask

  task automatic tick(input string name);
    obs_t e;
    @(negedge clock);
    reset = s.rst; miss_valid = s.mv; miss_addr = s.maddr; miss_is_store = s.st;
    miss_st_size = s.sz; miss_data = s.mdata; mem_grant = s.grant;
    mem2proc_transaction_tag = s.ttag; mem2proc_data_tag = s.dtag;
    mem2proc_data = s.ddata; dcache_refill_ready = s.ready;
    #1;
    got.cmd = proc2mem_command; got.paddr = proc2mem_addr; got.wr = mshr2Dcache_wr;
    got.waddr = mshr2Dcache_addr; got.blk = mshr2Dcache_mem_block;
    got.st = mshr2Dcache_is_store; got.sz = mshr2Dcache_st_size;
    got.data = mshr2Dcache_data; got.stall = mshr_stall; got.full = mshr_full;
    if (s.rst) model_clear();
    else begin
      model_step(e);
      chk(name, got, e);
    end
  endtask

  function automatic stim_t idle();
    stim_t r = '0;
    r.ready = 1'b1;
    return r;
  endfunction

  function automatic stim_t miss(input logic [31:0] a, input logic st, input logic [1:0] sz,
                                 input logic [31:0] d);
    stim_t r = idle();
    r.mv = 1'b1; r.maddr = a; r.st = st; r.sz = sz; r.mdata = d;
    return r;
  endfunction

  task automatic do_reset();
    s = idle(); s.rst = 1'b1;
    tick("reset");
    tick("reset");
  endtask

  function automatic obs_t refill_obs(input logic [31:0] a, input logic [63:0] b);
    obs_t o = '0;
    o.wr = 1'b1; o.waddr = a; o.blk = b;
    return o;
  endfunction

  function automatic logic [3:0] pick_free_tag();
    logic [3:0] t;
    bit used;
    for (int k = 0; k < 64; k++) begin
      t = 4'($urandom_range(1, 15));
      used = 1'b0;
      for (int i = 0; i < NE; i++) if (m_ph[i] == PWait && m_tag[i] == t) used = 1'b1;
      if (!used) return t;
    end
    return 4'd0;
  endfunction

  function automatic logic [3:0] pick_dtag();
    int r;
    int cand [$];
    r = int'($urandom_range(0, 3));
    if (r < 2) begin
      for (int i = 0; i < NE; i++) if (m_ph[i] == PWait) cand.push_back(i);
      if (cand.size() > 0) return m_tag[cand[$urandom_range(0, cand.size() - 1)]];
    end else if (r == 2) begin
      return 4'($urandom_range(1, 15));
    end
    return 4'd0;
  endfunction

  vec_t  vecs [$];
  obs_t  oa, ob, ex;
  vec_t  v;
  logic [63:0] blk_a;

  initial begin
    model_clear();
    do_reset();

    s = idle();
    tick("reset_state");
    chk("reset_outputs_zero", got, obs_t'(0));

    // Load miss: BUS_LOAD one cycle after the miss, refill one cycle after data (same with bypass).
    blk_a = 64'h1122_3344_5566_7788;
    v = '0; v.in = miss(32'h0000_1004, 1'b0, 2'd0, 32'h0); v.in.grant = 1'b1; v.in.ttag = 4'd3;
    vecs.push_back(v);
    v = '0; v.in = idle(); v.in.grant = 1'b1; v.in.ttag = 4'd3;
    v.exp.cmd = 2'd1; v.exp.paddr = 32'h0000_1000;
    vecs.push_back(v);
    for (int i = 0; i < 4; i++) begin
      v = '0; v.in = idle(); v.in.grant = 1'b1;
      vecs.push_back(v);
    end
    v = '0; v.in = idle(); v.in.grant = 1'b1; v.in.dtag = 4'd3; v.in.ddata = blk_a;
    v.exp = Byp ? refill_obs(32'h0000_1004, blk_a) : obs_t'(0);
    vecs.push_back(v);
    v = '0; v.in = idle(); v.in.grant = 1'b1;
    v.exp = Byp ? obs_t'(0) : refill_obs(32'h0000_1004, blk_a);
    vecs.push_back(v);
    v = '0; v.in = idle();
    vecs.push_back(v);
    for (int i = 0; i < vecs.size(); i++) begin
      s = vecs[i].in;
      tick("tbl_model");
      chk($sformatf("tbl_row%0d", i), got, vecs[i].exp);
    end

    // Store miss replays size and data with the refill.
    do_reset();
    s = miss(32'h0000_2006, 1'b1, 2'd1, 32'h0000_BEEF); tick("st_miss");
    s = idle(); s.grant = 1'b1; s.ttag = 4'd5; tick("st_issue");
    s = idle(); tick("st_wait");
    s = idle(); s.dtag = 4'd5; s.ddata = 64'hCAFE_F00D_0123_4567; tick("st_data");
    oa = got;
    s = idle(); tick("st_after");
    ob = got;
    ex = refill_obs(32'h0000_2006, 64'hCAFE_F00D_0123_4567);
    ex.st = 1'b1; ex.sz = 2'd1; ex.data = 32'h0000_BEEF;
    chk("store_refill", Byp ? oa : ob, ex);
    chk("store_no_second_wr", Byp ? ob : oa, obs_t'(0));

    // Four outstanding misses fill the file; a fifth and a same-block miss stall.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      s = miss(32'h0000_3000 + 32'(i * 8), 1'b0, 2'd0, 32'h0); s.grant = 1'b0;
      tick("fill");
    end
    s = miss(32'h0000_3020, 1'b0, 2'd0, 32'h0); tick("fifth");
    ex = '0; ex.stall = 1'b1; ex.full = 1'b1;
    chk("full_stall", got, ex);
    do_reset();
    s = miss(32'h0000_1004, 1'b0, 2'd0, 32'h0); tick("blk_first");
    s = miss(32'h0000_1000, 1'b0, 2'd0, 32'h0); tick("blk_second");
    ex = '0; ex.stall = 1'b1;
    chk("same_block_stall", got, ex);

    // Zero transaction tag retries with the same address.
    do_reset();
    s = miss(32'h0000_4000, 1'b0, 2'd0, 32'h0); tick("retry_miss");
    ex = '0; ex.cmd = 2'd1; ex.paddr = 32'h0000_4000;
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.grant = 1'b1; s.ttag = (i == 3) ? 4'd7 : 4'd0;
      tick("retry_issue");
      chk($sformatf("retry_cycle%0d", i), got, ex);
    end
    s = idle(); s.grant = 1'b1; s.ttag = 4'd9; tick("retry_done");
    chk("retry_no_reissue", got, obs_t'(0));
    s = idle(); s.dtag = 4'd3; s.ddata = 64'hDEAD; tick("retry_nomatch");
    chk("retry_wrong_tag", got, obs_t'(0));
    s = idle(); s.dtag = 4'd7; s.ddata = 64'h7777_0000_7777; tick("retry_data");
    oa = got;
    s = idle(); tick("retry_after");
    ob = got;
    chk("retry_refill", Byp ? oa : ob, refill_obs(32'h0000_4000, 64'h7777_0000_7777));

    // Out-of-order data with the refill port busy; drain lowest index first.
    do_reset();
    s = miss(32'h0000_5000, 1'b0, 2'd0, 32'h0); tick("ooo_a");
    s = miss(32'h0000_5008, 1'b0, 2'd0, 32'h0); s.grant = 1'b1; s.ttag = 4'd2; tick("ooo_b");
    s = idle(); s.grant = 1'b1; s.ttag = 4'd5; tick("ooo_issue_b");
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.ready = 1'b0;
      s.dtag = (i == 0) ? 4'd5 : ((i == 1) ? 4'd2 : 4'd0);
      s.ddata = (i == 0) ? 64'h5555 : 64'h2222;
      tick("ooo_hold");
      chk($sformatf("ooo_hold%0d", i), got, obs_t'(0));
    end
    s = idle(); tick("ooo_r0");
    chk("ooo_first", got, refill_obs(32'h0000_5000, 64'h2222));
    s = idle(); tick("ooo_r1");
    chk("ooo_second", got, refill_obs(32'h0000_5008, 64'h5555));
    s = idle(); tick("ooo_r2");
    chk("ooo_drained", got, obs_t'(0));

    // Reset during WAIT_DATA drops the late data tag.
    do_reset();
    s = miss(32'h0000_6000, 1'b0, 2'd0, 32'h0); tick("mr_miss");
    s = idle(); s.grant = 1'b1; s.ttag = 4'd4; tick("mr_issue");
    do_reset();
    s = idle(); s.dtag = 4'd4; s.ddata = 64'h4444; tick("mr_data");
    chk("midreset_drop", got, obs_t'(0));
    s = idle(); tick("mr_after");
    chk("midreset_quiet", got, obs_t'(0));

    // Randomized traffic over a few blocks to force collisions.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 399) == 0);
      s.mv    = 1'($urandom_range(0, 1));
      s.maddr = 32'h0000_7000 + 32'($urandom_range(0, 7) * 8) + 32'($urandom_range(0, 7));
      s.st    = 1'($urandom_range(0, 1));
      s.sz    = 2'($urandom_range(0, 3));
      s.mdata = $urandom;
      s.grant = ($urandom_range(0, 3) != 0);
      s.ttag  = ($urandom_range(0, 2) == 0) ? 4'd0 : pick_free_tag();
      s.dtag  = pick_dtag();
      s.ddata = {$urandom, $urandom};
      s.ready = ($urandom_range(0, 3) != 0);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
